serial_shifter: RTL and testbench

SERIAL_SHIFTER -- requirements
Module: serial_shifter

---
 rtl/serial_shifter_if.sv | 39 +++
 rtl/serial_shifter.sv | 110 +++++++++++
 tb/tb_serial_shifter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_shifter_if.sv
// Request/result handshake bundle for serial_shifter.
// i_rotate exists only when SERIAL_SHIFTER_ROTATE_EN is defined.
interface serial_shifter_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   logic               i_valid;
   logic               o_ready;
   logic               i_signed;
   logic               i_shift_left;
   logic [SHAMT_W-1:0] i_shift_amt;
   logic [WIDTH-1:0]   i_data;
`ifdef SERIAL_SHIFTER_ROTATE_EN
   logic               i_rotate;
`endif
   logic               o_valid;
   logic               i_ready;
   logic [WIDTH-1:0]   o_data;
   logic               o_busy;

   // Shifter side
   modport slave (
`ifdef SERIAL_SHIFTER_ROTATE_EN
      input  i_rotate,
`endif
      input  i_valid, i_signed, i_shift_left, i_shift_amt, i_data, i_ready,
      output o_ready, o_valid, o_data, o_busy
   );

   // Requester side
   modport master (
`ifdef SERIAL_SHIFTER_ROTATE_EN
      output i_rotate,
`endif
      output i_valid, i_signed, i_shift_left, i_shift_amt, i_data, i_ready,
      input  o_ready, o_valid, o_data, o_busy
   );
endinterface

// File: rtl/serial_shifter.sv
// Bit-serial shifter: one bit position per clock, result held until taken.
// Optional rotate mode enabled with macro SERIAL_SHIFTER_ROTATE_EN.
module serial_shifter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   serial_shifter_if.slave   bus
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [SHAMT_W-1:0] cnt;
   logic               left_q;
   logic               signed_q;
`ifdef SERIAL_SHIFTER_ROTATE_EN
   logic               rotate_q;
`endif
   logic               fill_l;
   logic               fill_r;
   logic [WIDTH-1:0]   shift_nxt;

   // Single-position step of the working register; o_data doubles as that register.
   always_comb begin
      fill_l    = 1'b0;
      fill_r    = signed_q & bus.o_data[WIDTH-1];
`ifdef SERIAL_SHIFTER_ROTATE_EN
      if (rotate_q) begin
         fill_l = bus.o_data[WIDTH-1];
         fill_r = bus.o_data[0];
      end
`endif
      shift_nxt = bus.o_data;
      if (left_q) begin
         shift_nxt = {bus.o_data[WIDTH-2:0], fill_l};
      end else begin
         shift_nxt = {fill_r, bus.o_data[WIDTH-1:1]};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         left_q      <= 1'b0;
         signed_q    <= 1'b0;
`ifdef SERIAL_SHIFTER_ROTATE_EN
         rotate_q    <= 1'b0;
`endif
         bus.o_ready <= 1'b0;
         bus.o_valid <= 1'b0;
         bus.o_busy  <= 1'b0;
         bus.o_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.o_ready && bus.i_valid) begin
                  left_q      <= bus.i_shift_left;
                  signed_q    <= bus.i_signed;
`ifdef SERIAL_SHIFTER_ROTATE_EN
                  rotate_q    <= bus.i_rotate;
`endif
                  bus.o_data  <= bus.i_data;
                  bus.o_ready <= 1'b0;
                  bus.o_busy  <= 1'b1;
                  cnt         <= bus.i_shift_amt;
                  if (bus.i_shift_amt == '0) begin
                     state       <= DONE;
                     bus.o_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end else begin
                  // Ready rises on the first edge after reset release
                  bus.o_ready <= 1'b1;
               end
            end
            SHIFT: begin
               bus.o_data <= shift_nxt;
               cnt        <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  state       <= DONE;
                  bus.o_valid <= 1'b1;
               end
            end
            DONE: begin
               // Handshake edge is not an accept edge; ready reopens for the next one
               if (bus.i_ready) begin
                  state       <= IDLE;
                  bus.o_valid <= 1'b0;
                  bus.o_busy  <= 1'b0;
                  bus.o_ready <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               bus.o_valid <= 1'b0;
               bus.o_busy  <= 1'b0;
               bus.o_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_shifter.sv
// Scoreboard bench for serial_shifter: driver pushes reference results, monitor pops on o_valid.
// Rotate cases compile in when SERIAL_SHIFTER_ROTATE_EN is defined.
module tb_serial_shifter;
   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  due;
   } exp_t;

   logic        clk;
   logic        rst;
   bit          ready_hold;
   int unsigned cyc;
   int unsigned checks;
   int unsigned errors;
   exp_t        sb[$];

   serial_shifter_if #(.WIDTH(W)) bus ();

   serial_shifter #(.WIDTH(W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: whole-word shift by the full amount
   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int unsigned amt,
                                              input bit left, input bit sgn, input bit rot);
      logic [W-1:0] r;
      if (rot) begin
         if (amt == 0) r = d;
         else if (left) r = (d << amt) | (d >> (W - amt));
         else r = (d >> amt) | (d << (W - amt));
      end else if (left) begin
         r = d << amt;
      end else if (sgn) begin
         r = W'($signed(d) >>> amt);
      end else begin
         r = d >> amt;
      end
      return r;
   endfunction

   // Downstream ready, changed just after each rising edge
   initial begin
      bus.i_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.i_ready = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops on each new result, then checks hold and post-handshake behaviour
   initial begin : monitor
      bit           in_valid;
      bit           hs_prev;
      logic [W-1:0] held;
      exp_t         e;
      in_valid = 1'b0;
      hs_prev  = 1'b0;
      held     = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_valid = 1'b0;
            hs_prev  = 1'b0;
         end else begin
            if (hs_prev) begin
               chk("ready_after_handshake", W'(bus.o_ready), W'(1));
               chk("valid_drop_after_handshake", W'(bus.o_valid), W'(0));
            end else if (in_valid) begin
               chk("valid_hold", W'(bus.o_valid), W'(1));
               chk("data_hold", bus.o_data, held);
            end
            if (bus.o_ready && bus.o_busy) chk("ready_while_busy", W'(1), W'(0));
            if (bus.o_valid && !in_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_valid", W'(1), W'(0));
               end else begin
                  e = sb.pop_front();
                  chk("result_data", bus.o_data, e.data);
                  chk("result_latency", W'(cyc), W'(e.due));
               end
               held = bus.o_data;
            end
            in_valid = bus.o_valid;
            hs_prev  = bus.o_valid && bus.i_ready;
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input int unsigned amt, input bit left,
                       input bit sgn, input bit rot);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!bus.o_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_ready) begin
         chk("accept_timeout", W'(0), W'(1));
         return;
      end
      bus.i_data       = d;
      bus.i_shift_amt  = 5'(amt);
      bus.i_shift_left = left;
      bus.i_signed     = sgn;
`ifdef SERIAL_SHIFTER_ROTATE_EN
      bus.i_rotate     = rot;
`endif
      bus.i_valid      = 1'b1;
      e.data = ref_shift(d, amt, left, sgn,
`ifdef SERIAL_SHIFTER_ROTATE_EN
                         rot
`else
                         1'b0 & rot
`endif
                        );
      e.due  = cyc + 1 + amt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      // Scramble inputs after accept; captured request must be unaffected
      bus.i_valid      = 1'b0;
      bus.i_data       = $urandom;
      bus.i_shift_amt  = 5'($urandom_range(0, 31));
      bus.i_shift_left = 1'($urandom_range(0, 1));
      bus.i_signed     = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.o_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || bus.o_busy) chk("drain_timeout", W'(sb.size()), W'(0));
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      ready_hold       = 1'b0;
      rst              = 1'b1;
      bus.i_valid      = 1'b0;
      bus.i_data       = '0;
      bus.i_shift_amt  = '0;
      bus.i_shift_left = 1'b0;
      bus.i_signed     = 1'b0;
`ifdef SERIAL_SHIFTER_ROTATE_EN
      bus.i_rotate     = 1'b0;
`endif
      #1;
      chk("reset_valid", W'(bus.o_valid), W'(0));
      chk("reset_data", bus.o_data, W'(0));
      chk("reset_busy", W'(bus.o_busy), W'(0));
      chk("reset_ready", W'(bus.o_ready), W'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_reset", W'(bus.o_ready), W'(1));

      // Directed cases
      send(32'h0000_00F0, 4, 1'b1, 1'b0, 1'b0);
      send(32'h8000_0000, 31, 1'b0, 1'b1, 1'b0);
      send(32'h8000_0000, 31, 1'b0, 1'b0, 1'b0);
      send(32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1'b0);
      send(32'h8000_0000, 4, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_SHIFTER_ROTATE_EN
      send(32'h8000_0001, 1, 1'b0, 1'b1, 1'b1);
      send(32'h8000_0001, 1, 1'b1, 1'b0, 1'b1);
`endif
      drain();

      // Result held with ready low; valid pulses while busy must be ignored
      ready_hold = 1'b1;
      repeat (2) @(negedge clk);
      send(32'h1234_5678, 3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.i_valid = 1'((i % 2) == 0);
         bus.i_data  = $urandom;
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("done_hold_valid", W'(bus.o_valid), W'(1));
      ready_hold = 1'b0;
      drain();

      // Reset while counter is 3 of a 10-position shift
      send(32'hA5A5_0F0F, 10, 1'b0, 1'b1, 1'b0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      sb.delete();
      chk("midrst_valid", W'(bus.o_valid), W'(0));
      chk("midrst_data", bus.o_data, W'(0));
      chk("midrst_busy", W'(bus.o_busy), W'(0));
      chk("midrst_ready", W'(bus.o_ready), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_midrst", W'(bus.o_ready), W'(1));
      repeat (15) @(negedge clk);
      chk("midrst_no_valid", W'(bus.o_valid), W'(0));

      // Random sweep
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send($urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
